// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, column/row counters,
// and registered sync/blank/strobe decodes aligned with the counters.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HT_LAST  = CW'(HT - 1);
  localparam logic [CW-1:0] VT_LAST  = CW'(VT - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);

  logic [DW-1:0] div_q;
  logic [CW-1:0] x_q, y_q, x_next, y_next;
  logic          hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic [15:0]   frame_cnt_q;
  logic          div_last, wrap_line, wrap_frame;

  assign div_last = (div_q == DIV_LAST);
  // Strobe is combinational from the divider so it coincides with the counting edge.
  assign pix_en   = en & ~rst & div_last;

  always_comb begin
    x_next     = x_q;
    y_next     = y_q;
    wrap_line  = 1'b0;
    wrap_frame = 1'b0;
    if (pix_en) begin
      if (x_q == HT_LAST) begin
        x_next    = '0;
        wrap_line = 1'b1;
        if (y_q == VT_LAST) begin
          y_next     = '0;
          wrap_frame = 1'b1;
        end else begin
          y_next = y_q + 1'b1;
        end
      end else begin
        x_next = x_q + 1'b1;
      end
    end
  end

  // Decodes are computed from the next counter values so they land on the
  // same edge as the counters themselves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (en) begin
      div_q         <= div_last ? '0 : div_q + 1'b1;
      x_q           <= x_next;
      y_q           <= y_next;
      hsync_q       <= ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? H_POL : ~H_POL;
      vsync_q       <= ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? V_POL : ~V_POL;
      video_on_q    <= (x_next < H_VIS) && (y_next < V_VIS);
      line_start_q  <= wrap_line;
      frame_start_q <= wrap_frame;
      if (wrap_frame) frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign px_x        = x_q;
  assign px_y        = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  // Pulses are masked while frozen so a pulse cannot linger into an en=0 cycle.
  assign line_start  = line_start_q & en;
  assign frame_start = frame_start_q & en;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, back porch in lines.
REQ-009 SHALL have parameter H_POL, default 0, hsync active level.
REQ-010 SHALL have parameter V_POL, default 0, vsync active level.
REQ-011 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel, legal range >= 1.
REQ-012 SHALL have parameter CW, default 10, coordinate width; 2^CW >= H and V totals.
REQ-013 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-014 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-015 SHALL have port en, input, 1 bit: run enable; low freezes all timing state.
REQ-016 SHALL have port pix_en, output, 1 bit: one-clk pixel strobe.
REQ-017 SHALL have ports hsync and vsync, outputs, 1 bit each, polarity per H_POL/V_POL.
REQ-018 SHALL have port video_on, output, 1 bit: high when px_x < H_ACTIVE and px_y < V_ACTIVE.
REQ-019 SHALL have ports px_x and px_y, outputs, CW bits each: current column and row.
REQ-020 SHALL have ports line_start and frame_start, outputs, 1 bit each: one-clk pulses.
REQ-021 SHALL have port frame_cnt, output, 16 bits: completed-frame counter.

Function
REQ-022 H total HT = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V total VT = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
REQ-023 Line order: active, front porch, sync, back porch; frame order is the same in lines.
REQ-024 Divider counts 0..CLK_DIV-1 on clk while en=1; pix_en=1 for exactly the clk where the divider equals CLK_DIV-1 and en=1.
REQ-025 CLK_DIV=1 gives pix_en=1 on every clk with en=1.
REQ-026 On a clk with pix_en=1, px_x increments; at HT-1 it wraps to 0 and px_y increments.
REQ-027 px_y wraps from VT-1 to 0 only on a clk with pix_en=1 and px_x=HT-1.
REQ-028 hsync=H_POL when H_ACTIVE+H_FRONT <= px_x <= H_ACTIVE+H_FRONT+H_SYNC-1; otherwise hsync=~H_POL.
REQ-029 vsync is the same decode on px_y using V parameters and V_POL.
REQ-030 hsync, vsync, video_on, line_start and frame_start are registered and aligned to the px_x/px_y values of the same clk; there is zero-cycle skew between them.
REQ-031 line_start=1 for the single clk on which px_x becomes 0.
REQ-032 frame_start=1 for the single clk on which (px_x,px_y) becomes (0,0); line_start is also 1 on that clk.
REQ-033 frame_cnt increments by 1 with each frame_start and wraps from 16'hFFFF to 0.
REQ-034 en=0 holds divider, counters and all outputs; pix_en, line_start and frame_start are 0. Counting resumes from the held divider value once en returns to 1.

Reset
REQ-035 rst=1 forces the following immediately: divider=0, px_x=0, px_y=0, frame_cnt=0, pix_en=0, line_start=0, frame_start=0, hsync=~H_POL, vsync=~V_POL, video_on=1.
REQ-036 Reset mid-line or mid-frame abandons the frame; after release, the first pix_en occurs CLK_DIV clks later (with en=1), and no frame_start pulses for the reset position.

Verification
REQ-037 Defaults, en=1, reset release: pix_en every 2nd clk; hsync low exactly for px_x 656..751; line_start period is 1600 clk.
REQ-038 Defaults: vsync low for px_y 490..491; frame_start period is 840000 clk; frame_cnt reads 3 after three frames.
REQ-039 H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, H_POL=V_POL=1: px_x sequence is 0..7 repeating; hsync high at px_x 5,6; video_on high only for px_x<4 and px_y<3; frame period is 48 clk.
REQ-040 Drop en for 7 clk at px_x=100: px_x stays 100 and pix_en stays 0 throughout; the next pix_en follows the held divider phase.
REQ-041 Assert rst at px_y=300: all outputs take their REQ-035 values in the same cycle; after release the sequence restarts from (0,0), and frame_cnt=0.
REQ-042 Force frame_cnt to 16'hFFFF, run one frame: frame_cnt=0 on that frame's frame_start.
